// File: rtl/i3c_pkg.sv
// i3c_pkg: bus-state encoding and default parameter values shared by the I3C bus condition detector
package i3c_pkg;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int FILT_LEN_DEF        = 3;
    localparam int BUS_FREE_CYCLES_DEF = 16;
    localparam logic [1:0] ST_FREE      = 2'd0;
    localparam logic [1:0] ST_BUSY      = 2'd1;
    localparam logic [1:0] ST_WAIT_FREE = 2'd2;
endpackage

// File: rtl/i3c_sync_filter.sv
// i3c_sync_filter: pad synchronizer with optional glitch filter
// Filter present only when I3C_GLITCH_FILTER_EN is defined; otherwise the last sync flop is the level.
module i3c_sync_filter
    import i3c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
`ifdef I3C_GLITCH_FILTER_EN
    logic [3:0] r_cnt;
    logic       r_level;
    // the level flips only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (r_sync[SYNC_STAGES-1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == 4'(FILT_LEN - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync[SYNC_STAGES-1];
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end
    assign o_level = r_level;
`else
    assign o_level = r_sync[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/i3c_bus_cond_detector.sv
// i3c_bus_cond_detector: START/repeated-START/STOP detection and bus busy/free tracking
// Glitch filter on the bus lines is enabled by defining I3C_GLITCH_FILTER_EN.
module i3c_bus_cond_detector
    import i3c_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int FILT_LEN        = FILT_LEN_DEF,
    parameter int BUS_FREE_CYCLES = BUS_FREE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rising,
    output logic scl_falling,
    output logic start_detected,
    output logic rstart_detected,
    output logic stop_detected,
    output logic bus_busy,
    output logic bus_free
);
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_idle_cnt;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl_hi;
    logic       w_start;
    logic       w_stop;

    i3c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .rst(rst), .i_raw(scl_in), .o_level(scl_f)
    );
    i3c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .rst(rst), .i_raw(sda_in), .o_level(sda_f)
    );

    // SCL must be stable high across the SDA edge, so simultaneous changes never qualify
    assign w_scl_hi = scl_f & r_scl_prev;
    assign w_start  = w_scl_hi & r_sda_prev & ~sda_f;
    assign w_stop   = w_scl_hi & ~r_sda_prev & sda_f;

    always_comb begin
        w_next_state = w_start ? ST_BUSY :
                       (r_state == ST_BUSY && w_stop) ? ST_WAIT_FREE :
                       (r_state == ST_WAIT_FREE && r_idle_cnt == 8'(BUS_FREE_CYCLES)) ? ST_FREE :
                       r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_prev      <= 1'b1;
            r_sda_prev      <= 1'b1;
            scl_rising      <= 1'b0;
            scl_falling     <= 1'b0;
            start_detected  <= 1'b0;
            rstart_detected <= 1'b0;
            stop_detected   <= 1'b0;
            r_state         <= ST_WAIT_FREE;
            r_idle_cnt      <= 8'd0;
        end else begin
            r_scl_prev      <= scl_f;
            r_sda_prev      <= sda_f;
            scl_rising      <= scl_f & ~r_scl_prev;
            scl_falling     <= ~scl_f & r_scl_prev;
            start_detected  <= w_start;
            rstart_detected <= w_start & (r_state == ST_BUSY);
            stop_detected   <= w_stop;
            r_state         <= w_next_state;
            r_idle_cnt      <= (r_state != ST_WAIT_FREE || w_stop || !(scl_f && sda_f)) ? 8'd0 :
                               r_idle_cnt + {7'd0, r_idle_cnt != 8'hFF};
        end
    end

    assign bus_busy = (r_state == ST_BUSY);
    assign bus_free = (r_state == ST_FREE);
endmodule

// File: tb/tb_i3c_bus_cond_detector.sv
// tb_i3c_bus_cond_detector: directed table, corner sequences and random stimulus against a history-based model
// Honours I3C_GLITCH_FILTER_EN the same way as the design.
module tb_i3c_bus_cond_detector;
    localparam int NS  = 2;
    localparam int FL  = 3;
    localparam int BFC = 16;
    localparam int HL  = 16384;
`ifdef I3C_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
    localparam logic [31:0] GLITCH_EXP = {10'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`else
    localparam bit FILT_ON = 1'b0;
    localparam logic [31:0] GLITCH_EXP = {10'd0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0};
`endif

    logic clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1;
    logic scl_f, sda_f, scl_rising, scl_falling, start_detected, rstart_detected, stop_detected;
    logic bus_busy, bus_free;

    always #5 clk = ~clk;

    i3c_bus_cond_detector #(.SYNC_STAGES(NS), .FILT_LEN(FL), .BUS_FREE_CYCLES(BFC)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rising(scl_rising), .scl_falling(scl_falling),
        .start_detected(start_detected), .rstart_detected(rstart_detected),
        .stop_detected(stop_detected), .bus_busy(bus_busy), .bus_free(bus_free)
    );

    int n_chk = 0, n_pass = 0;

    // model: per-line raw/synced/filtered history indexed by clock edges since reset
    bit raw_h [2][HL];
    bit syn_h [2][HL];
    bit flt_h [2][HL];
    int m_e, m_state, m_idle;
    logic [8:0] m_vec;
    int c_st, c_rs, c_sp, c_sr, c_sf;

    typedef struct {
        bit scl, sda;
        int hold;
        bit busy, free;
        int st, rs, sp, sr, sf;
    } row_t;
    row_t rows [15];

    function automatic logic [31:0] pk(bit b, bit f, int st, int rs, int sp, int sr, int sf);
        return {10'd0, b, f, st[3:0], rs[3:0], sp[3:0], sr[3:0], sf[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        m_e = 0;
        for (int l = 0; l < 2; l++) begin
            raw_h[l][0] = 1'b1;
            syn_h[l][0] = 1'b1;
            flt_h[l][0] = 1'b1;
        end
        m_state = 2;
        m_idle  = 0;
        m_vec   = 9'b110000000;
    endtask

    task automatic model_step(input bit s, input bit d);
        bit f1 [2];
        bit f2 [2];
        bit st, sp, rs, same, v, b;
        int ns;
        m_e++;
        raw_h[0][m_e] = s;
        raw_h[1][m_e] = d;
        for (int l = 0; l < 2; l++) begin
            syn_h[l][m_e] = (m_e - NS + 1 >= 1) ? raw_h[l][m_e - NS + 1] : 1'b1;
            if (FILT_ON) begin
                // level takes value v once the last FL samples seen by the filter all equal v
                v = syn_h[l][m_e - 1];
                same = 1'b1;
                for (int k = 1; k <= FL; k++) begin
                    b = (m_e - k >= 0) ? syn_h[l][m_e - k] : 1'b1;
                    if (b != v) same = 1'b0;
                end
                flt_h[l][m_e] = same ? v : flt_h[l][m_e - 1];
            end else begin
                flt_h[l][m_e] = syn_h[l][m_e];
            end
            f1[l] = flt_h[l][m_e - 1];
            f2[l] = (m_e >= 2) ? flt_h[l][m_e - 2] : 1'b1;
        end
        st = f1[0] && f2[0] && !f1[1] && f2[1];
        sp = f1[0] && f2[0] && f1[1] && !f2[1];
        rs = st && m_state == 1;
        ns = m_state;
        if (st) ns = 1;
        else if (sp && m_state == 1) ns = 2;
        else if (m_state == 2 && m_idle == BFC) ns = 0;
        if (m_state == 2 && !sp && f1[0] && f1[1]) m_idle = (m_idle < 255) ? m_idle + 1 : 255;
        else m_idle = 0;
        m_state = ns;
        m_vec = {flt_h[0][m_e], flt_h[1][m_e], f1[0] & ~f2[0], ~f1[0] & f2[0], st, rs, sp,
                 m_state == 1, m_state == 0};
    endtask

    task automatic cyc(input bit r, input bit s, input bit d);
        @(negedge clk);
        rst = r;
        scl_in = s;
        sda_in = d;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else model_step(s, d);
        check("cycle", {23'd0, scl_f, sda_f, scl_rising, scl_falling, start_detected,
                        rstart_detected, stop_detected, bus_busy, bus_free}, {23'd0, m_vec});
        c_st += int'(start_detected);
        c_rs += int'(rstart_detected);
        c_sp += int'(stop_detected);
        c_sr += int'(scl_rising);
        c_sf += int'(scl_falling);
    endtask

    task automatic clr_counts();
        c_st = 0; c_rs = 0; c_sp = 0; c_sr = 0; c_sf = 0;
    endtask

    initial begin
        rows[0]  = '{1, 1, 30, 0, 1, 0, 0, 0, 0, 0};
        rows[1]  = '{1, 0, 10, 1, 0, 1, 0, 0, 0, 0};
        rows[2]  = '{0, 0, 10, 1, 0, 0, 0, 0, 0, 1};
        rows[3]  = '{1, 0, 10, 1, 0, 0, 0, 0, 1, 0};
        rows[4]  = '{1, 1, 10, 0, 0, 0, 0, 1, 0, 0};
        rows[5]  = '{1, 1,  5, 0, 0, 0, 0, 0, 0, 0};
        rows[6]  = '{0, 0,  7, 0, 0, 0, 0, 0, 0, 1};
        rows[7]  = '{1, 1, 12, 0, 0, 0, 0, 0, 1, 0};
        rows[8]  = '{1, 1, 20, 0, 1, 0, 0, 0, 0, 0};
        rows[9]  = '{1, 0, 10, 1, 0, 1, 0, 0, 0, 0};
        rows[10] = '{0, 0, 10, 1, 0, 0, 0, 0, 0, 1};
        rows[11] = '{0, 1, 10, 1, 0, 0, 0, 0, 0, 0};
        rows[12] = '{1, 1, 10, 1, 0, 0, 0, 0, 1, 0};
        rows[13] = '{1, 0, 10, 1, 0, 1, 1, 0, 0, 0};
        rows[14] = '{0, 0, 10, 1, 0, 0, 0, 0, 0, 1};
        clr_counts();
        repeat (3) cyc(1, 1, 1);
        check("reset_state", {23'd0, scl_f, sda_f, scl_rising, scl_falling, start_detected,
                              rstart_detected, stop_detected, bus_busy, bus_free}, 32'h180);
        for (int i = 0; i < 15; i++) begin
            clr_counts();
            for (int h = 0; h < rows[i].hold; h++) cyc(0, rows[i].scl, rows[i].sda);
            check($sformatf("row%0d", i), pk(bus_busy, bus_free, c_st, c_rs, c_sp, c_sr, c_sf),
                  pk(rows[i].busy, rows[i].free, rows[i].st, rows[i].rs, rows[i].sp, rows[i].sr, rows[i].sf));
        end
        // reset while BUSY: drop to WAIT_FREE silently, then recover to FREE
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        check("rst_mid_busy", {23'd0, scl_f, sda_f, scl_rising, scl_falling, start_detected,
                               rstart_detected, stop_detected, bus_busy, bus_free}, 32'h180);
        clr_counts();
        for (int i = 0; i < 25; i++) cyc(0, 1, 1);
        check("after_rst_idle", pk(bus_busy, bus_free, c_st, c_rs, c_sp, c_sr, c_sf),
              pk(0, 1, 0, 0, 0, 0, 0));
        // two-cycle SDA glitch while SCL is high
        clr_counts();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1);
        check("sda_glitch", pk(bus_busy, bus_free, c_st, c_rs, c_sp, c_sr, c_sf), GLITCH_EXP);
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                bit s, d;
                int h;
                s = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
                h = $urandom_range(1, 8);
                for (int k = 0; k < h; k++) cyc(0, s, d);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i3c_bus_cond_detector.md
I3C_BUS_COND_DETECTOR -- requirements
Module: i3c_bus_cond_detector

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per bus line (min 2).
REQ-002 SHALL have parameter FILT_LEN, default 3, consecutive stable cycles needed before a filtered level changes (1..15).
REQ-003 SHALL have parameter BUS_FREE_CYCLES, default 16, idle-high cycles after STOP before bus_free asserts (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port scl_in  input  1  raw SCL from pad.
REQ-007 SHALL have port sda_in  input  1  raw SDA from pad (input side of the slave's inout).
REQ-008 SHALL have port scl_f  output  1  synchronized/filtered SCL level.
REQ-009 SHALL have port sda_f  output  1  synchronized/filtered SDA level.
REQ-010 SHALL have port scl_rising  output  1  one-cycle pulse on scl_f 0->1.
REQ-011 SHALL have port scl_falling  output  1  one-cycle pulse on scl_f 1->0.
REQ-012 SHALL have port start_detected  output  1  one-cycle pulse on any START or repeated START.
REQ-013 SHALL have port rstart_detected  output  1  one-cycle pulse on repeated START only.
REQ-014 SHALL have port stop_detected  output  1  one-cycle pulse on STOP.
REQ-015 SHALL have port bus_busy  output  1  high from START to STOP.
REQ-016 SHALL have port bus_free  output  1  high once bus idle for BUS_FREE_CYCLES.

Function
REQ-017 SHALL pass each line through SYNC_STAGES flops, then a filter updating the filtered level only after the synced value differs from it for FILT_LEN consecutive cycles; any bounce restarts the count.
REQ-018 SHALL generate all pulse outputs as registered compares of current vs previous filtered levels; latency raw edge -> pulse = SYNC_STAGES + FILT_LEN + 1 cycles.
REQ-019 SHALL detect START when sda_f falls while scl_f is high in both the current and previous cycle.
REQ-020 SHALL detect STOP when sda_f rises while scl_f is high in both the current and previous cycle.
REQ-021 SHALL NOT flag START/STOP when scl_f and sda_f change in the same cycle; only scl edge pulses result.
REQ-022 SHALL implement states FREE, BUSY, WAIT_FREE: FREE/WAIT_FREE --START--> BUSY; BUSY --STOP--> WAIT_FREE; WAIT_FREE --counter==BUS_FREE_CYCLES--> FREE.
REQ-023 SHALL assert rstart_detected (with start_detected) only for a START seen in BUSY; state stays BUSY.
REQ-024 SHALL, in WAIT_FREE, count cycles with scl_f=1 and sda_f=1, clearing the 8-bit counter whenever either is low; the counter saturates and never wraps.
REQ-025 SHALL drive bus_busy=1 exactly in BUSY and bus_free=1 exactly in FREE.
REQ-026 SHALL ignore STOP in FREE/WAIT_FREE except restarting the WAIT_FREE counter; stop_detected still pulses.

Reset
REQ-027 SHALL on rst load synchronizer flops, filtered and previous levels with 1 (idle bus), filter counters 0, idle counter 0, state WAIT_FREE.
REQ-028 SHALL hold every pulse output 0, bus_busy 0, bus_free 0 during and in the cycle after reset; reset mid-transfer discards BUSY with no stop_detected.

Configuration
REQ-029 SHALL, with macro I3C_GLITCH_FILTER_EN defined, include the filter of REQ-017.
REQ-030 SHALL, without I3C_GLITCH_FILTER_EN, bypass the filter (filtered = last synchronizer stage), latency SYNC_STAGES + 1, FILT_LEN unused.

Structure
REQ-031 SHALL take the bus-state encoding (FREE, BUSY, WAIT_FREE) and default parameter constants from shared package i3c_pkg.
REQ-032 SHALL instantiate sub-module i3c_sync_filter twice (SCL, SDA), containing synchronizer plus optional filter.

Verification
REQ-033 SHALL cover: reset, then SCL=SDA=1 for 20 cycles -> bus_free=1 at cycle 16 of idle, no pulses.
REQ-034 SHALL cover: SCL=1, SDA 1->0 -> one start_detected, rstart_detected=0, bus_busy=1 at latency 6 (defaults).
REQ-035 SHALL cover: inside transfer, SCL high, SDA 1->0 -> start_detected and rstart_detected both pulse once, bus_busy stays 1.
REQ-036 SHALL cover: SCL=1, SDA 0->1 -> stop_detected once, bus_busy=0, bus_free after 16 idle cycles; SDA low at cycle 10 restarts count.
REQ-037 SHALL cover: 2-cycle SDA glitch with SCL high (filter on) -> no pulse; filter off -> START/STOP pair.
REQ-038 SHALL cover: SCL and SDA toggled same cycle -> scl edge pulse only; rst mid-BUSY -> WAIT_FREE, no stop_detected.
